// File: rtl/adc_mux_seq.sv
// adc_mux_seq: N-channel ADC selector with registered output, post-switch blanking and
// round-robin auto-scan. Define ADC_MUX_BLANK_ZERO_EN to drive adc_o to zero while blanking.
module adc_mux_seq #(
    parameter int unsigned  NCH       = 4,
    parameter int unsigned  DW        = 16,
    parameter int unsigned  BLANK_CYC = 4,
    parameter int unsigned  DWELL_W   = 16,
    localparam int unsigned SW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*DW-1:0] adc_i,
    input  logic [SW-1:0]     sel_i,
    input  logic              mode_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic [DW-1:0]     adc_o,
    output logic [SW-1:0]     ch_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              wrap_o
);

    localparam int unsigned BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

    typedef enum logic {
        StBlank = 1'b0,
        StTrack = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [BW-1:0]        blank_cnt_q, blank_cnt_d;
    logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic [SW-1:0]        ch_q, ch_d;
    logic [DW-1:0]        adc_q, adc_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 wrap_q, wrap_d;

    logic [DW-1:0]        sample;
    logic [DW-1:0]        blank_fill;
    logic                 manual_switch;
    logic                 blank_term;
    logic                 dwell_term;
    logic                 ch_last;
    logic [SW-1:0]        ch_next;

    always_comb begin
        sample = '0;
        for (int k = 0; k < NCH; k++) begin
            if (32'(ch_q) == k) begin
                sample = adc_i[k*DW +: DW];
            end
        end
    end

`ifdef ADC_MUX_BLANK_ZERO_EN
    assign blank_fill = '0;
`else
    assign blank_fill = adc_q;
`endif

    assign manual_switch = !mode_i && (sel_i != ch_q) && (32'(sel_i) < NCH);
    assign blank_term    = (32'(blank_cnt_q) == BLANK_CYC - 1);
    // A dwell of 0 behaves as 1; >= lets a shortened dwell take effect on the next edge.
    assign dwell_term    = (dwell_i <= DWELL_W'(1)) || (dwell_cnt_q >= dwell_i - DWELL_W'(1));
    assign ch_last       = (32'(ch_q) == NCH - 1);
    assign ch_next       = ch_last ? '0 : ch_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        dwell_cnt_d = dwell_cnt_q;
        ch_d        = ch_q;
        adc_d       = adc_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        wrap_d      = 1'b0;

        if (manual_switch) begin
            ch_d        = sel_i;
            state_d     = StBlank;
            blank_cnt_d = '0;
            dwell_cnt_d = '0;
            adc_d       = blank_fill;
            valid_d     = 1'b0;
            busy_d      = 1'b1;
        end else begin
            unique case (state_q)
                StBlank: begin
                    dwell_cnt_d = '0;
                    if (blank_term) begin
                        // The terminal blank edge already loads settled data.
                        state_d     = StTrack;
                        blank_cnt_d = '0;
                        adc_d       = sample;
                        valid_d     = 1'b1;
                        busy_d      = 1'b0;
                    end else begin
                        blank_cnt_d = blank_cnt_q + 1'b1;
                    end
                end
                StTrack: begin
                    adc_d   = sample;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    if (!mode_i) begin
                        dwell_cnt_d = '0;
                    end else if (dwell_term) begin
                        ch_d        = ch_next;
                        wrap_d      = ch_last;
                        state_d     = StBlank;
                        blank_cnt_d = '0;
                        dwell_cnt_d = '0;
                        adc_d       = blank_fill;
                        valid_d     = 1'b0;
                        busy_d      = 1'b1;
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StBlank;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StBlank;
            blank_cnt_q <= '0;
            dwell_cnt_q <= '0;
            ch_q        <= '0;
            adc_q       <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b1;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            blank_cnt_q <= blank_cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
            ch_q        <= ch_d;
            adc_q       <= adc_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            wrap_q      <= wrap_d;
        end
    end

    assign adc_o   = adc_q;
    assign ch_o    = ch_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign wrap_o  = wrap_q;

endmodule

// File: doc/adc_mux_seq.md
Name: adc_mux_seq

Overview:
Parametrised N-channel ADC selector with registered output, the successor of the two-input adc_muxing block. It sits between the ADC capture registers and the lock-in/PID datapath. After every channel change it blanks its output for a fixed number of cycles so downstream filters do not see switching transients. It supports manual channel selection and an automatic round-robin scan with a programmable dwell time.

Parameters:
NCH, 4, number of input channels (2..16)
DW, 16, sample width in bits
SW, $clog2(NCH) (minimum 1), channel index width (derived, not overridable)
BLANK_CYC, 4, blanking length in cycles after a channel change (at least 1)
DWELL_W, 16, width of the dwell-time input

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
adc_i  in  NCH*DW  packed samples; channel k occupies bits [k*DW +: DW]
sel_i  in  SW  manual channel select (used only when mode_i=0)
mode_i  in  1  0 = manual, 1 = auto-scan
dwell_i  in  DWELL_W  auto-scan TRACK cycles per channel; 0 is treated as 1
adc_o  out  DW  selected sample, registered
ch_o  out  SW  channel currently routed to adc_o
valid_o  out  1  high when adc_o holds settled data
busy_o  out  1  high while blanking
wrap_o  out  1  one-cycle pulse on auto-scan wrap from NCH-1 to 0

Behaviour:
- rst is asynchronous and active-high.
- Reset values: adc_o=0, ch_o=0, valid_o=0, busy_o=1, wrap_o=0, state=BLANK, blank_cnt=0, dwell_cnt=0.
- Two states: BLANK and TRACK.
- BLANK:
  - blank_cnt increments every cycle. valid_o=0 and busy_o=1. adc_o holds its last value.
  - When blank_cnt==BLANK_CYC-1, the next state is TRACK.
  - After reset release there are exactly BLANK_CYC cycles with valid_o=0.
- TRACK:
  - Every edge: adc_o <= adc_i[ch_o], valid_o <= 1, busy_o <= 0.
  - Latency is one cycle from the adc_i sample to adc_o.
- Manual mode (mode_i=0), in either state:
  - If sel_i != ch_o and sel_i < NCH: ch_o <= sel_i, blank_cnt <= 0, state <= BLANK, valid_o <= 0.
  - A new differing sel_i during BLANK restarts blanking with the new channel.
  - sel_i >= NCH is ignored; ch_o is unchanged.
- Auto mode (mode_i=1):
  - sel_i is ignored. dwell_cnt increments in TRACK.
  - When dwell_cnt == max(dwell_i,1)-1: ch_o advances (NCH-1 wraps to 0), dwell_cnt <= 0, state <= BLANK.
  - wrap_o=1 for exactly the cycle in which ch_o changes from NCH-1 to 0.
  - dwell_cnt holds at 0 during BLANK.
- Mode changes:
  - 0→1 clears dwell_cnt and keeps the current channel.
  - 1→0 applies the manual rule on the same cycle.
- dwell_i changing mid-dwell takes effect immediately. If dwell_cnt is already past the new limit, the channel advances on the next cycle.
- Reset asserted at any time, including mid-blank or mid-dwell, forces all reset values immediately, with no clock needed.
- All arithmetic is unsigned; counters never overflow because they reset on terminal count.

Optional Feature:
ADC_MUX_BLANK_ZERO_EN
- Defined: adc_o is forced to 0 on the edge that enters BLANK and stays 0 throughout blanking.
- Undefined: adc_o holds the last TRACK sample during BLANK.
- Either way, valid_o timing is identical.

Test Plan:
1. Defaults, manual mode, sel_i=0, ch0=12, ch1=16, release rst → valid_o=0 for 4 cycles, then valid_o=1 and adc_o=12 with ch_o=0.
2. In TRACK, sel_i 0→1 → next edge ch_o=1 and valid_o=0; adc_o holds 12 for 4 cycles, then adc_o=16 with valid_o=1. With ADC_MUX_BLANK_ZERO_EN defined, adc_o=0 during those 4 cycles.
3. Separate instance with NCH=3, in TRACK on ch0, sel_i=3 → ch_o stays 0, valid_o stays 1, no blanking. Then sel_i=2 during BLANK of a prior switch → blanking restarts, ch_o=2, and 4 full blank cycles follow.
4. Auto mode, dwell_i=10, ch k carries value 100+k → ch_o sequence 0,1,2,3,0. Each channel gives 10 valid cycles with adc_o=100+k, separated by 4 invalid cycles. wrap_o pulses once every 56 cycles.
5. Auto mode with dwell_i=0 → each channel gets 1 valid cycle then 4 blank cycles; period is 20 cycles.
6. Assert rst asynchronously, between clock edges, mid-blank on ch2 → outputs go to reset values before the next edge. After release, the scan resumes from ch0 with a 4-cycle blank.
